// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   dm_state_e  : arbiter sequencer states (IDLE, ACCESS, DONE)
//   PORT0/PORT1 : requester indices as carried on owner / gnt_idx
//   DM_ADDR_W   : default byte-address width toward the memory
//   DM_DATA_W   : default data width
// Configuration macro: DM_ARB_FIXED_PRIO_EN (see rr_arb2 / dm_arbiter).
// ---------------------------------------------------------------------------
package dm_arb_pkg;

   localparam int DM_ADDR_W = 8;
   localparam int DM_DATA_W = 8;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } dm_state_e;

endpackage : dm_arb_pkg

// File: rtl/dm_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way pick between requesters 0 and 1.
//   req_i[1:0] : raw request lines
//   ptr_i      : preferred port when both request (round-robin pointer)
//   gnt_idx_o  : index of the winning port (PORT0 when nobody requests)
//   any_req_o  : at least one request present
// Configuration macro: DM_ARB_FIXED_PRIO_EN -- when defined, port 0 always
// wins a tie and ptr_i is ignored.
// ---------------------------------------------------------------------------
module rr_arb2
   import dm_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   output logic       gnt_idx_o,
   output logic       any_req_o
);

`ifdef DM_ARB_FIXED_PRIO_EN
   // The pointer has no meaning with a fixed priority order.
   logic unused_ptr;
   assign unused_ptr = ptr_i;
`endif

   always_comb begin
      any_req_o = |req_i;
      gnt_idx_o = PORT0;
      if (req_i == 2'b10) begin
         gnt_idx_o = PORT1;
      end else if (req_i == 2'b11) begin
`ifdef DM_ARB_FIXED_PRIO_EN
         gnt_idx_o = PORT0;
`else
         gnt_idx_o = ptr_i;
`endif
      end
   end

endmodule : rr_arb2

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Two-requester arbiter/sequencer in front of a single-port synchronous-read
// data memory (read-before-write). Each access takes IDLE -> ACCESS -> DONE.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0           : port 0 request (CPU FSM)
//   done0/rdata0                    : port 0 completion pulse and read data
//   req1/we1/addr1/wdata1           : port 1 request (loader/debug)
//   done1/rdata1                    : port 1 completion pulse and read data
//   mem_addr/mem_din/mem_we         : memory address/data/write-enable
//   mem_dout                        : memory read data (registered in memory)
//   busy                            : high while in ACCESS or DONE
//   owner                           : port currently or last granted
//   state_dbg                       : current FSM state (dm_state_e encoding)
// Configuration macro: DM_ARB_FIXED_PRIO_EN -- port 0 wins ties and the
// round-robin pointer is removed; default build is round-robin.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
// stable until doneN. Inputs are sampled only in IDLE. doneN is a one-cycle
// pulse and rdataN is valid while it is high (old contents on a write).
// Keeping reqN high after doneN requests another access; dropping reqN
// after the grant does not abort the access in flight.
// ---------------------------------------------------------------------------
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic              owner,
   output logic [1:0]        state_dbg
);

   dm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              mem_we_q, mem_we_d;
   logic              owner_q, owner_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              arb_ptr;
   logic              gnt_idx;
   logic              any_req;

`ifdef DM_ARB_FIXED_PRIO_EN
   assign arb_ptr = PORT0;
`else
   logic rr_ptr_q, rr_ptr_d;
   assign arb_ptr = rr_ptr_q;
`endif

   rr_arb2 u_pick (
      .req_i     ({req1, req0}),
      .ptr_i     (arb_ptr),
      .gnt_idx_o (gnt_idx),
      .any_req_o (any_req)
   );

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = mem_we_q;
      owner_d    = owner_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
`ifndef DM_ARB_FIXED_PRIO_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ACCESS;
               owner_d = gnt_idx;
               if (gnt_idx == PORT1) begin
                  mem_addr_d = addr1;
                  mem_din_d  = wdata1;
                  mem_we_d   = we1;
               end else begin
                  mem_addr_d = addr0;
                  mem_din_d  = wdata0;
                  mem_we_d   = we0;
               end
            end
         end
         ACCESS: begin
            // The memory acts on the edge that leaves ACCESS.
            state_d  = DONE;
            mem_we_d = 1'b0;
         end
         DONE: begin
            // mem_dout now holds the word as it was before this access.
            state_d = IDLE;
            if (owner_q == PORT1) begin
               done1_d  = 1'b1;
               rdata1_d = mem_dout;
            end else begin
               done0_d  = 1'b1;
               rdata0_d = mem_dout;
            end
`ifndef DM_ARB_FIXED_PRIO_EN
            rr_ptr_d = ~owner_q;
`endif
         end
         default: begin
            state_d  = IDLE;
            mem_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         owner_q    <= PORT0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         owner_q    <= owner_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

`ifndef DM_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= PORT0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign mem_we    = mem_we_q;
   assign owner     = owner_q;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
   import dm_arb_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic       done0, done1, mem_we, busy, owner;
   logic [7:0] rdata0, rdata1, mem_addr, mem_din;
   logic [7:0] mem_dout = '0;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .done0(done0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .done1(done1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout), .busy(busy), .owner(owner), .state_dbg(state_dbg)
   );

   // Read-before-write single-port memory, word = addr[7:1].
   // Initial contents: word w holds w ^ 8'hC3.
   logic [7:0] mem [0:127];
   initial for (int w = 0; w < 128; w++) mem[w] = 8'(w) ^ 8'hC3;
   always @(posedge clk) begin
      mem_dout <= mem[mem_addr[7:1]];
      if (mem_we) mem[mem_addr[7:1]] <= mem_din;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [8:0] exp_q[$];        // {port, expected rdata}
   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   logic [7:0] trk0 = '0, trk1 = '0;
   bit         spacing_on = 0;
   bit         prev_valid = 0;
   int         prev_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_port(input logic p, input logic we, input logic [7:0] a, input logic [7:0] wd);
      if (p) begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
      else   begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
   endtask

   task automatic do_access(input logic p, input logic we, input logic [7:0] a,
                            input logic [7:0] wd, input logic [7:0] exp_rd);
      bit seen = 0;
      exp_q.push_back({p, exp_rd});
      set_port(p, we, a, wd);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if ((p ? done1 : done0) === 1'b1) begin seen = 1; break; end
      end
      check("done_timeout", 32'(seen), 32'd1);
      if (p) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic wait_dones(input int target);
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (done_cnt >= target) begin seen = 1; break; end
      end
      check("held_timeout", 32'(seen), 32'd1);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      trk0 = '0;
      trk1 = '0;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [8:0] e;
      logic       p;
      forever begin
         @(negedge clk);
         if (rst_n && (done0 || done1)) begin
            check("done_exclusive", 32'(done0 & done1), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               p = done1;
               check("grant_port", 32'(p), 32'(e[8]));
               check("rdata", 32'(p ? rdata1 : rdata0), 32'(e[7:0]));
               check("nonowner_rdata", 32'(p ? rdata0 : rdata1), 32'(p ? trk0 : trk1));
               if (e[8]) trk1 = e[7:0]; else trk0 = e[7:0];
               done_cnt++;
               if (spacing_on) begin
                  if (prev_valid) check("done_spacing", 32'(cyc - prev_cyc), 32'd3);
                  prev_valid = 1;
                  prev_cyc = cyc;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int base;
      // Reset with req0 already high: everything stays at zero.
      assert_reset();
      set_port(PORT0, 1'b0, 8'h04, 8'h00);
      repeat (2) @(negedge clk);
      check("rst_done0", 32'(done0), 32'd0);
      check("rst_done1", 32'(done1), 32'd0);
      check("rst_rdata0", 32'(rdata0), 32'd0);
      check("rst_rdata1", 32'(rdata1), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      // Release: word 2 = 0x02^0xC3 = 0xC1, done0 three edges later.
      exp_q.push_back({PORT0, 8'hC1});
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lat++;
         if (done0) break;
      end
      check("release_latency", 32'(lat), 32'd3);
      req0 = 1'b0;
      @(negedge clk);

      // Port 0 write 0x10 <- 0xA5 returns old word 8 (0xCB); port 1 reads it.
      do_access(PORT0, 1'b1, 8'h10, 8'hA5, 8'hCB);
      do_access(PORT1, 1'b0, 8'h10, 8'h00, 8'hA5);
      // Alias: write 0x21 (word 0x10, old 0xD3), read back through 0x20.
      do_access(PORT1, 1'b1, 8'h21, 8'h3C, 8'hD3);
      do_access(PORT0, 1'b0, 8'h20, 8'h00, 8'h3C);

      // Both requests held from reset.
      assert_reset();
      set_port(PORT0, 1'b0, 8'h10, 8'h00);
      set_port(PORT1, 1'b0, 8'h20, 8'h00);
      repeat (2) @(negedge clk);
      spacing_on = 1;
      prev_valid = 0;
      base = done_cnt;
`ifdef DM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) exp_q.push_back({PORT0, 8'hA5});
      rst_n = 1'b1;
      wait_dones(base + 4);
      req0 = 1'b0;
      exp_q.push_back({PORT1, 8'h3C});
      wait_dones(base + 5);
      req1 = 1'b0;
`else
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({PORT0, 8'hA5});
         exp_q.push_back({PORT1, 8'h3C});
      end
      rst_n = 1'b1;
      wait_dones(base + 6);
      req0 = 1'b0;
      req1 = 1'b0;
`endif
      repeat (4) @(negedge clk);
      spacing_on = 0;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a write's ACCESS cycle.
      set_port(PORT0, 1'b1, 8'h30, 8'h77);
      @(posedge clk); #1;
      check("mid_state_access", 32'(state_dbg), 32'(ACCESS));
      check("mid_mem_we_high", 32'(mem_we), 32'd1);
      assert_reset();
      #1;
      check("mid_mem_we_drop", 32'(mem_we), 32'd0);
      check("mid_busy_drop", 32'(busy), 32'd0);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_idle", 32'(state_dbg), 32'(IDLE));
      check("post_rst_no_done", 32'(done0 | done1), 32'd0);
      // Normal service afterwards: word 9 = 0x09^0xC3 = 0xCA.
      do_access(PORT1, 1'b0, 8'h12, 8'h00, 8'hCA);
      repeat (3) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dm_arbiter

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 8-bit data memory (addressr / dataIn / writeEnable / dataOut, synchronous read).
- Serialises requests from port 0 (CPU FSM) and port 1 (loader/debug) onto the memory with round-robin fairness.
- Returns read data to the granted port with a one-cycle done pulse.
- Sits between the requester FSMs and the memory instance; the memory's read timing is hidden from requesters.

Parameters:
- ADDR_W, 8, byte address width driven to the memory (memory ignores bit 0).
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request, held until done0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- done0  out  1  port 0 access complete, one-cycle pulse
- rdata0  out  DATA_W  port 0 read data, valid while done0=1
- req1, we1, addr1, wdata1, done1, rdata1: same as port 0, for port 1
- mem_addr  out  ADDR_W  to memory addressr
- mem_din  out  DATA_W  to memory dataIn
- mem_we  out  1  to memory writeEnable
- mem_dout  in  DATA_W  from memory dataOut (registered in memory)
- busy  out  1  high in ACCESS and DONE
- owner  out  1  index of the port currently or last granted

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_we=0; mem_addr=0; mem_din=0; done0=done1=0; rdata0=rdata1=0; busy=0; owner=0; rr_ptr=0 (port 0 preferred first).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant that port.
  - If both req, grant the port selected by rr_ptr.
  - On grant, register addr/wdata/we of the winner into mem_addr/mem_din/mem_we and set owner. Next state is ACCESS.
- ACCESS (1 cycle):
  - Memory ports are driven; mem_we equals the latched we.
  - The memory performs its write or read at the end of this cycle.
  - Next state is DONE, and mem_we returns to 0.
- DONE (1 cycle):
  - done[owner]=1; rdata[owner]=mem_dout for both reads and writes. On a write, the value returned is the old contents, because the memory is read-before-write.
  - rr_ptr becomes the other port (~owner).
  - Next state is IDLE.
- Latency: req sampled high in IDLE at edge N → done high in the cycle after edge N+2. Three cycles per access. Max throughput is 1 access per 3 cycles total, shared.
- Requester rules:
  - Hold req/we/addr/wdata stable until done. Inputs are only sampled in IDLE.
  - A requester may keep req high after done for back-to-back accesses; it is re-arbitrated in IDLE.
  - Dropping req after grant does not abort; the access completes and done still pulses.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1.
- Address aliasing: addresses 2k and 2k+1 hit the same word. The arbiter passes the address unmodified and does not check it.
- Ordering: accesses complete in grant order. A write by one port followed by a read of the same word by the other returns the new data.
- The non-owner's done is 0 and its rdata holds its last value.
- Reset mid-access: immediate return to IDLE, mem_we=0, no done issued, and the in-flight write is not guaranteed.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests; rr_ptr is removed. Port 1 can starve while req0 is held.
- Undefined (default): round-robin as above.

Decomposition:
- Package dm_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - constants PORT0=0, PORT1=1;
  - default ADDR_W/DATA_W localparams.
- One sub-module, rr_arb2: a combinational 2-way pick with inputs req[1:0] and ptr, outputs gnt_idx and any_req. The macro selects the fixed-priority variant inside it.

Test Plan:
- Reset: hold rst_n=0 with req0=1 → all outputs 0. Release → grant port 0; done0 pulses 3 cycles after release edge.
- Port 0 write addr=0x10 wdata=0xA5, then port 1 read addr=0x10 → done1 with rdata1=0xA5. Port 0's write done returns the prior contents.
- Alias: write 0x3C to addr 0x21, read addr 0x20 → 0x3C.
- Both reqs held continuously from reset, 6 accesses → grant order 0,1,0,1,0,1; exactly one done per 3 cycles; done0 and done1 are never high together.
- DM_ARB_FIXED_PRIO_EN defined, both reqs held for 4 accesses → all grants to port 0 and done1 never asserts. Drop req0 → port 1 is served next.
- Assert rst_n=0 during ACCESS of a write → mem_we drops asynchronously, no done. After release, the FSM is in IDLE and serves the next request normally.
